core_fpu_issue: RTL

CORE_FPU_ISSUE -- requirements
Module: core_fpu_issue

---
 rtl/core_fpu_pkg.sv | 34 +++
 rtl/fpu_watchdog.sv | 26 ++
 rtl/core_fpu_issue.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/core_fpu_pkg.sv
// Shared definitions for the FP issue block: op codes, fop bit map,
// FSM state encoding and the set of ops that write the integer file.
package core_fpu_pkg;

    localparam int NUM_OPS = 10;

    // Op codes; the fop strobe bit for an op is the bit at its op code.
    localparam logic [3:0] OP_FADDS  = 4'd0;
    localparam logic [3:0] OP_FSUBS  = 4'd1;
    localparam logic [3:0] OP_FMULS  = 4'd2;
    localparam logic [3:0] OP_FDIVS  = 4'd3;
    localparam logic [3:0] OP_FEQS   = 4'd4;
    localparam logic [3:0] OP_FLTS   = 4'd5;
    localparam logic [3:0] OP_FLES   = 4'd6;
    localparam logic [3:0] OP_FCVTSW = 4'd7;
    localparam logic [3:0] OP_FCVTWS = 4'd8;
    localparam logic [3:0] OP_FSQRTS = 4'd9;

    // Ops whose result goes to the integer register file (feqs, flts, fles, fcvtws),
    // laid out on the same bit map as fop.
    localparam logic [NUM_OPS-1:0] INT_DEST_OPS = 10'b01_0111_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= OP_FSQRTS;
    endfunction

endpackage

// File: rtl/fpu_watchdog.sv
// Counts cycles spent waiting on the FPU and flags the last allowed cycle.
module fpu_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count_reg;

    // Count enabled cycles from zero; clear whenever the wait is not active.
    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            count_reg <= 8'd0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    // Expired on the LIMIT-th enabled cycle, so the wait lasts exactly LIMIT cycles.
    assign expired = enable && (count_reg == 8'(LIMIT - 1));

endmodule

// File: rtl/core_fpu_issue.sv
// Issues one decoded FP instruction at a time to the FPU, stalls the pipe
// while the FPU works, and produces a one-cycle writeback or an error pulse.
module core_fpu_issue
    import core_fpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_frs1,
    input  logic [31:0] req_frs2,
    output logic        req_ready,
    input  logic        flush,
    output logic [9:0]  fop,
    output logic [31:0] rs1,
    output logic [31:0] frs1,
    output logic [31:0] frs2,
    output logic        stole,
    input  logic [31:0] fpu_result,
    input  logic        tvalid_once,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_to_int,
    output logic        busy,
    output logic        err_timeout,
    output logic        err_illegal
);

    state_t state_reg, state_next;

    logic [3:0]         op_reg;
    logic [4:0]         rd_reg;
    logic [31:0]        rs1_reg, frs1_reg, frs2_reg;
    logic [31:0]        wb_data_reg;
    logic               err_timeout_reg, err_illegal_reg;
    logic [NUM_OPS-1:0] op_onehot;
    logic               accept, accept_legal, wait_expired, in_wait;

    assign accept       = (state_reg == ST_IDLE) && req_valid;
    assign accept_legal = accept && op_is_legal(req_op);
    assign in_wait      = (state_reg == ST_WAIT);

    fpu_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (!in_wait),
        .enable  (in_wait),
        .expired (wait_expired)
    );

    // Decode the latched op into its fop strobe bit.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPS; gi++) begin : g_fop
            assign op_onehot[gi] = (op_reg == 4'(gi));
        end
    endgenerate

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; flush beats completion, completion beats timeout.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  if (accept_legal) state_next = ST_ISSUE;
            ST_ISSUE: state_next = flush ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
                if (flush)             state_next = ST_IDLE;
                else if (tvalid_once)  state_next = ST_DONE;
                else if (wait_expired) state_next = ST_IDLE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Request latches, result capture and one-cycle error pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_reg          <= 4'd0;
            rd_reg          <= 5'd0;
            rs1_reg         <= 32'd0;
            frs1_reg        <= 32'd0;
            frs2_reg        <= 32'd0;
            wb_data_reg     <= 32'd0;
            err_timeout_reg <= 1'b0;
            err_illegal_reg <= 1'b0;
        end else begin
            err_illegal_reg <= accept && !op_is_legal(req_op);
            err_timeout_reg <= in_wait && !flush && !tvalid_once && wait_expired;
            if (accept_legal) begin
                op_reg   <= req_op;
                rd_reg   <= req_rd;
                rs1_reg  <= req_rs1;
                frs1_reg <= req_frs1;
                frs2_reg <= req_frs2;
            end
            if (in_wait && tvalid_once && !flush) begin
                wb_data_reg <= fpu_result;
            end
        end
    end

    // Outputs derived from state and latched request.
    always_comb begin
        fop         = '0;
        stole       = 1'b0;
        wb_valid    = 1'b0;
        wb_to_int   = 1'b0;
        busy        = (state_reg != ST_IDLE);
        req_ready   = (state_reg == ST_IDLE) && !RST;
        unique case (state_reg)
            ST_ISSUE: fop = op_onehot;
            ST_WAIT: begin
                fop   = op_onehot;
                stole = 1'b1;
            end
            ST_DONE: begin
                wb_valid  = 1'b1;
                wb_to_int = |(op_onehot & INT_DEST_OPS);
            end
            default: ;
        endcase
    end

    assign rs1         = rs1_reg;
    assign frs1        = frs1_reg;
    assign frs2        = frs2_reg;
    assign wb_rd       = rd_reg;
    assign wb_data     = wb_data_reg;
    assign err_timeout = err_timeout_reg;
    assign err_illegal = err_illegal_reg;

endmodule
